pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Issue/hazard controller for the in-order iDEA pipeline.
- Sits between decode and the DSP execute stages (EX1-EX3, MEM, WB).
- Tracks in-flight destination registers in a shift scoreboard and stalls decode on read-after-write hazards, because the core has no forwarding.
- On a taken branch resolved in EX3, squashes younger in-flight instructions and drives a multi-cycle flush to fetch/decode.

Parameters:
- REG_ADDR_W, 5: register address width.
- DEPTH, 6: scoreboard entries, equal to the number of pipeline slots from issue to register-file write completion.
- BR_STAGE, 3: scoreboard index holding the branch when it resolves. Legal range 0 to DEPTH-2.
- FLUSH_LEN, 2: cycles flush_o is held after a taken branch. Minimum 1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- id_valid_i, in, 1: decode holds a valid instruction.
- id_rs_a_i, in, REG_ADDR_W: source A address.
- id_rs_a_use_i, in, 1: source A is read.
- id_rs_b_i, in, REG_ADDR_W: source B address.
- id_rs_b_use_i, in, 1: source B is read.
- id_rd_i, in, REG_ADDR_W: destination address.
- id_we_i, in, 1: instruction writes the register file (word or upper-halfword).
- branch_taken_i, in, 1: EX3 branch resolved taken this cycle.
- issue_o, out, 1: decode instruction enters EX1 this cycle.
- stall_o, out, 1: hold PC and IF/ID registers.
- flush_o, out, 1: kill IF/ID contents; fetch from branch target.
- stall_cnt_o, out, 16: saturating count of stall cycles.

Behaviour:
- Reset (async, immediate):
  - All scoreboard entries invalid; state RUN; flush counter 0; stall_cnt_o = 0.
  - Combinational outputs then evaluate as in RUN with an empty scoreboard.
- Scoreboard: DEPTH entries {valid, rd}. Index 0 is youngest. Every posedge it shifts unconditionally; index DEPTH-1 drops out. There is no backpressure after issue.
- New entry 0 = {1, id_rd_i} if issue_o and id_we_i; otherwise {0, x}.
- hazard (combinational) = id_valid_i and, for some valid entry e:
  - (id_rs_a_use_i and e.rd == id_rs_a_i), or
  - (id_rs_b_use_i and e.rd == id_rs_b_i).
  - Register 0 is not special.
- FSM states: RUN, FLUSH.
- RUN:
  - issue_o = id_valid_i & ~hazard & ~branch_taken_i.
  - stall_o = hazard & ~branch_taken_i.
  - flush_o = 0.
- RUN with branch_taken_i = 1:
  - The ID instruction is not issued and no stall is reported; the flush takes priority over the hazard.
  - At the posedge, post-shift entries 0..BR_STAGE are forced invalid. These are the instructions younger than the branch.
  - The branch itself moves to index BR_STAGE+1 and is retained.
  - Next state FLUSH; counter loads FLUSH_LEN-1.
- FLUSH:
  - flush_o = 1, issue_o = 0, stall_o = 0.
  - The counter decrements each cycle; at 0 the FSM returns to RUN.
  - flush_o is therefore high for exactly FLUSH_LEN cycles, starting the cycle after branch_taken_i.
  - branch_taken_i is ignored in FLUSH; no younger branch can be valid.
- stall_cnt_o increments by 1 at each posedge where stall_o = 1, and holds at 16'hFFFF.
- Latency:
  - stall_o and issue_o are same-cycle combinational from the inputs and registered state.
  - flush_o is registered; it rises 1 cycle after branch_taken_i.
- Reset mid-FLUSH: flush_o drops immediately; no residual flush after release.

Test Plan:
- Reset, then id_valid_i = 1 with use flags = 0, no hazards -> issue_o = 1 every cycle, stall_o = 0, flush_o = 0, stall_cnt_o = 0.
- RAW hazard:
  - Stimulus: issue rd = 5, we = 1 at cycle 0. From cycle 1, ID holds rs_a = 5, use = 1.
  - Response: stall_o = 1 in cycles 1-6, issue_o = 1 at cycle 7, stall_cnt_o = 6.
- Same sequence with id_rs_a_use_i = 0 at cycle 1 -> no stall, issue_o = 1 at cycle 1. Repeat via rs_b, use = 1 -> 6-cycle stall.
- Taken branch, DEPTH = 6, BR_STAGE = 3, FLUSH_LEN = 2:
  - Stimulus: issue rd = 1, 2, 3, 4 in cycles 0-3; branch_taken_i = 1 in cycle 4.
  - Cycle 4: issue_o = 0, stall_o = 0.
  - flush_o = 1 in cycles 5-6; issue_o = 1 again in cycle 7.
  - rd 2/3/4 entries invalidated: rs = 3 at cycle 7 does not stall.
  - rd = 1 survives: rs = 1 presented at cycle 5 would stall in RUN until it drops after cycle 6.
- Simultaneous events: hazard on rd = 5 plus branch_taken_i in the same cycle -> stall_o = 0, issue_o = 0, FLUSH entered, stall_cnt_o unchanged for that cycle.
- Assert rst during cycle 5 of the branch test -> flush_o = 0 and all entries cleared without waiting for a clock edge. After release, rs = 1 does not stall and stall_cnt_o = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : RAW stall and taken-branch flush control for the iDEA pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 6,
  parameter int BR_STAGE   = 3,
  parameter int FLUSH_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_a_i,
  input  logic                  id_rs_a_use_i,
  input  logic [REG_ADDR_W-1:0] id_rs_b_i,
  input  logic                  id_rs_b_use_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  branch_taken_i,
  output logic                  issue_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [15:0]           stall_cnt_o
);

  localparam int              c_CNT_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [c_CNT_W-1:0] c_FLUSH_LAST = c_CNT_W'(FLUSH_LEN - 1);
  localparam logic [0:0]      c_RUN        = 1'b0;
  localparam logic [0:0]      c_FLUSH      = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [c_CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [DEPTH-1:0]      sb_valid_q, sb_valid_d;
  logic [REG_ADDR_W-1:0] sb_rd_q [DEPTH];
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic [DEPTH-1:0]      w_match;
  logic                  w_hazard;
  logic                  w_run;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
      assign w_match[g] = sb_valid_q[g] &
                          ((id_rs_a_use_i & (sb_rd_q[g] == id_rs_a_i)) |
                           (id_rs_b_use_i & (sb_rd_q[g] == id_rs_b_i)));
    end
  endgenerate

  assign w_hazard    = id_valid_i & (|w_match);
  assign w_run       = (state_q == c_RUN);
  // A resolving branch outranks any hazard: nothing issues and no stall is counted.
  assign issue_o     = w_run & id_valid_i & ~w_hazard & ~branch_taken_i;
  assign stall_o     = w_run & w_hazard & ~branch_taken_i;
  assign flush_o     = (state_q == c_FLUSH);
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    sb_valid_d  = {sb_valid_q[DEPTH-2:0], issue_o & id_we_i};
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (w_run) begin
      if (branch_taken_i) begin
        state_d     = c_FLUSH;
        flush_cnt_d = c_FLUSH_LAST;
        // Everything younger than the branch lands in slots 0..BR_STAGE after the shift.
        for (int i = 0; i <= BR_STAGE; i++) begin
          sb_valid_d[i] = 1'b0;
        end
      end
    end else begin
      if (flush_cnt_q == '0) begin
        state_d = c_RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_RUN;
      flush_cnt_q <= '0;
      sb_valid_q  <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sb_rd_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      sb_valid_q  <= sb_valid_d;
      stall_cnt_q <= stall_cnt_d;
      sb_rd_q[0]  <= id_rd_i;
      for (int i = 1; i < DEPTH; i++) begin
        sb_rd_q[i] <= sb_rd_q[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed and random checks of pipe_hazard_ctrl against an age-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int RW        = 5;
  localparam int DEPTH     = 6;
  localparam int BR_STAGE  = 3;
  localparam int FLUSH_LEN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid_i, id_rs_a_use_i, id_rs_b_use_i, id_we_i, branch_taken_i;
  logic [RW-1:0] id_rs_a_i, id_rs_b_i, id_rd_i;
  logic          issue_o, stall_o, flush_o;
  logic [15:0]   stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_W(RW), .DEPTH(DEPTH), .BR_STAGE(BR_STAGE), .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i),
    .id_rs_a_i(id_rs_a_i), .id_rs_a_use_i(id_rs_a_use_i),
    .id_rs_b_i(id_rs_b_i), .id_rs_b_use_i(id_rs_b_use_i),
    .id_rd_i(id_rd_i), .id_we_i(id_we_i),
    .branch_taken_i(branch_taken_i),
    .issue_o(issue_o), .stall_o(stall_o), .flush_o(flush_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: each in-flight writer is tracked by its age in cycles since issue.
  typedef struct {
    int rd;
    int age;
  } wr_t;
  wr_t inflight[$];
  int  flush_left;
  int  m_cnt;

  function automatic bit m_hazard();
    bit found = 1'b0;
    foreach (inflight[k]) begin
      if ((id_rs_a_use_i && inflight[k].rd == int'(id_rs_a_i)) ||
          (id_rs_b_use_i && inflight[k].rd == int'(id_rs_b_i)))
        found = 1'b1;
    end
    return id_valid_i && found;
  endfunction

  function automatic bit m_issue();
    return (flush_left == 0) && id_valid_i && !m_hazard() && !branch_taken_i;
  endfunction

  function automatic bit m_stall();
    return (flush_left == 0) && m_hazard() && !branch_taken_i;
  endfunction

  task automatic model_reset();
    inflight.delete();
    flush_left = 0;
    m_cnt      = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input bit v, input int ra, input bit rau, input int rb, input bit rbu,
                       input int rd, input bit we, input bit br);
    id_valid_i     = v;
    id_rs_a_i      = RW'(ra);
    id_rs_a_use_i  = rau;
    id_rs_b_i      = RW'(rb);
    id_rs_b_use_i  = rbu;
    id_rd_i        = RW'(rd);
    id_we_i        = we;
    branch_taken_i = br;
    #4;
    check("issue", {31'd0, issue_o}, {31'd0, m_issue()});
    check("stall", {31'd0, stall_o}, {31'd0, m_stall()});
    check("flush", {31'd0, flush_o}, {31'd0, flush_left > 0});
    check("stall_cnt", {16'd0, stall_cnt_o}, m_cnt);
  endtask

  task automatic clock();
    bit  e_issue = m_issue();
    bit  e_stall = m_stall();
    bit  in_fl   = (flush_left > 0);
    wr_t nq[$];
    @(posedge clk);
    foreach (inflight[k]) begin
      if (inflight[k].age + 1 <= DEPTH) nq.push_back('{rd: inflight[k].rd, age: inflight[k].age + 1});
    end
    if (e_issue && id_we_i) nq.push_back('{rd: int'(id_rd_i), age: 1});
    if (in_fl) begin
      flush_left--;
    end else if (branch_taken_i) begin
      inflight.delete();
      foreach (nq[k]) if (nq[k].age > BR_STAGE + 1) inflight.push_back(nq[k]);
      nq = inflight;
      flush_left = FLUSH_LEN;
    end
    inflight = nq;
    if (e_stall && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      clock();
    end
  endtask

  initial begin
    rst = 1'b1;
    id_valid_i = 0; id_rs_a_i = '0; id_rs_a_use_i = 0; id_rs_b_i = '0;
    id_rs_b_use_i = 0; id_rd_i = '0; id_we_i = 0; branch_taken_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    rst = 1'b0;

    // No sources read: issue every cycle.
    for (int i = 0; i < 4; i++) begin
      apply(1, i, 0, i + 1, 0, i, 0, 0);
      check("free_issue", {31'd0, issue_o}, 32'd1);
      clock();
    end

    // RAW on source A: six stall cycles.
    apply(1, 0, 0, 0, 0, 5, 1, 0);
    clock();
    for (int i = 1; i <= 7; i++) begin
      apply(1, 5, 1, 0, 0, 0, 0, 0);
      check("rawa_stall", {31'd0, stall_o}, {31'd0, i <= 6});
      check("rawa_issue", {31'd0, issue_o}, {31'd0, i == 7});
      clock();
    end
    check("rawa_cnt", {16'd0, stall_cnt_o}, 32'd6);

    // Source A not used: no stall.
    apply(1, 0, 0, 0, 0, 5, 1, 0);
    clock();
    apply(1, 5, 0, 0, 0, 0, 0, 0);
    check("nouse_issue", {31'd0, issue_o}, 32'd1);
    clock();
    idle(DEPTH);

    // RAW on source B.
    apply(1, 0, 0, 0, 0, 5, 1, 0);
    clock();
    for (int i = 1; i <= 7; i++) begin
      apply(1, 0, 0, 5, 1, 0, 0, 0);
      check("rawb_stall", {31'd0, stall_o}, {31'd0, i <= 6});
      clock();
    end
    check("rawb_cnt", {16'd0, stall_cnt_o}, 32'd12);

    // Taken branch with rd 1..4 in flight.
    for (int i = 1; i <= 4; i++) begin
      apply(1, 0, 0, 0, 0, i, 1, 0);
      clock();
    end
    apply(1, 0, 0, 0, 0, 9, 1, 1);
    check("br_issue", {31'd0, issue_o}, 32'd0);
    check("br_stall", {31'd0, stall_o}, 32'd0);
    clock();
    for (int i = 5; i <= 6; i++) begin
      apply(1, 1, 1, 0, 0, 0, 0, 0);
      check("br_flush", {31'd0, flush_o}, 32'd1);
      clock();
    end
    apply(1, 3, 1, 0, 0, 0, 0, 0);
    check("br_post_issue", {31'd0, issue_o}, 32'd1);
    check("br_post_flush", {31'd0, flush_o}, 32'd0);
    clock();
    idle(DEPTH);

    // Hazard and branch in the same cycle.
    apply(1, 0, 0, 0, 0, 5, 1, 0);
    clock();
    apply(1, 5, 1, 0, 0, 0, 0, 1);
    check("sim_stall", {31'd0, stall_o}, 32'd0);
    check("sim_issue", {31'd0, issue_o}, 32'd0);
    clock();
    check("sim_flush", {31'd0, flush_o}, 32'd1);
    check("sim_cnt", {16'd0, stall_cnt_o}, 32'd12);
    idle(DEPTH + 2);

    // Asynchronous reset in the middle of a flush.
    for (int i = 1; i <= 4; i++) begin
      apply(1, 0, 0, 0, 0, i, 1, 0);
      clock();
    end
    apply(1, 0, 0, 0, 0, 0, 0, 1);
    clock();
    apply(1, 1, 1, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("arst_flush", {31'd0, flush_o}, 32'd0);
    check("arst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    apply(1, 1, 1, 0, 0, 0, 0, 0);
    check("arst_nostall", {31'd0, stall_o}, 32'd0);
    clock();

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      apply(bit'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 15) == 0));
      clock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
